// File: rtl/axi_burst_master_if.sv
// AXI3 bus bundle between the burst master engine and a slave.
// The master modport drives the AW/W/AR channels and the B/R ready signals.
interface axi_if_t #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 32,
  parameter int LEN_W  = 4
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]    awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]    arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// AXI3 master engine: one command becomes one INCR burst, one transaction in flight.
// Optional watchdog enabled by defining AXI_MST_TIMEOUT_EN.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int ID_W    = 32,
  parameter int LEN_W   = 4,
  parameter int MST_ID  = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic [1:0]          done_resp,
  output logic                done_lenerr,
  output logic [2:0]          dbg_state,
  axi_if_t.master             axi
);
  // Every channel transfers on the cycle where its valid and ready are both high;
  // valid never waits for ready, and the stream pass-throughs are combinational.
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  localparam logic [2:0] SIZE = 3'($clog2(DATA_W/8));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    beat_q, beat_d;
  logic [1:0]        resp_q, resp_d;
  logic              done_q, done_d;
  logic [1:0]        done_resp_q, done_resp_d;
  logic              done_lenerr_q, done_lenerr_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any, last_w, tmo_hit;

  assign aw_hs  = (state_q == S_AW) && axi.awready;
  assign w_hs   = (state_q == S_W)  && wr_valid && axi.wready;
  assign b_hs   = (state_q == S_B)  && axi.bvalid;
  assign ar_hs  = (state_q == S_AR) && axi.arready;
  assign r_hs   = (state_q == S_R)  && axi.rvalid && rd_ready;
  assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign last_w = (beat_q == {1'b0, len_q});

`ifdef AXI_MST_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q != S_IDLE) && !hs_any && (tmo_q == 32'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q + 32'd1;
    if (state_q == S_IDLE || hs_any) tmo_d = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (areset) tmo_q <= 32'd0;
    else        tmo_q <= tmo_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit = 1'b0;
`endif

  logic unused_ids;
  assign unused_ids = ^{axi.bid, axi.rid};

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      resp_q        <= 2'b00;
      done_q        <= 1'b0;
      done_resp_q   <= 2'b00;
      done_lenerr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      resp_q        <= resp_d;
      done_q        <= done_d;
      done_resp_q   <= done_resp_d;
      done_lenerr_q <= done_lenerr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    resp_d        = resp_q;
    done_d        = 1'b0;
    done_resp_d   = done_resp_q;
    done_lenerr_d = done_lenerr_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = cmd_write ? S_AW : S_AR;
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        beat_d  = '0;
        resp_d  = 2'b00;
      end
      S_AW: if (aw_hs) state_d = S_W;
      S_W: if (w_hs) begin
        beat_d = beat_q + 1'b1;
        if (last_w) state_d = S_B;
      end
      S_B: if (b_hs) begin
        state_d       = S_IDLE;
        done_d        = 1'b1;
        done_resp_d   = axi.bresp[1] ? axi.bresp : 2'b00;
        done_lenerr_d = 1'b0;
      end
      S_AR: if (ar_hs) state_d = S_R;
      S_R: if (r_hs) begin
        // Saturate so an over-long burst can never wrap back onto len.
        beat_d = (&beat_q) ? beat_q : beat_q + 1'b1;
        if (resp_q == 2'b00 && axi.rresp[1]) resp_d = axi.rresp;
        if (axi.rlast) begin
          state_d       = S_IDLE;
          done_d        = 1'b1;
          done_resp_d   = (resp_q != 2'b00) ? resp_q : (axi.rresp[1] ? axi.rresp : 2'b00);
          done_lenerr_d = (beat_q != {1'b0, len_q});
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d       = S_IDLE;
      done_d        = 1'b1;
      done_resp_d   = 2'b11;
      done_lenerr_d = 1'b0;
    end
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    wr_ready    = (state_q == S_W) && axi.wready;
    rd_valid    = (state_q == S_R) && axi.rvalid;
    rd_data     = axi.rdata;
    rd_last     = (state_q == S_R) && axi.rlast;
    done        = done_q;
    done_resp   = done_resp_q;
    done_lenerr = done_lenerr_q;
    dbg_state   = state_q;

    axi.awid    = ID_W'(MST_ID);
    axi.awaddr  = addr_q;
    axi.awlen   = len_q;
    axi.awsize  = SIZE;
    axi.awburst = 2'b01;
    axi.awlock  = 2'b00;
    axi.awcache = 4'b0000;
    axi.awprot  = 3'b000;
    axi.awvalid = (state_q == S_AW);

    axi.wid     = ID_W'(MST_ID);
    axi.wdata   = wr_data;
    axi.wstrb   = wr_strb;
    axi.wlast   = (state_q == S_W) && last_w;
    axi.wvalid  = (state_q == S_W) && wr_valid;

    axi.bready  = (state_q == S_B);

    axi.arid    = ID_W'(MST_ID);
    axi.araddr  = addr_q;
    axi.arlen   = len_q;
    axi.arsize  = SIZE;
    axi.arburst = 2'b01;
    axi.arlock  = 2'b00;
    axi.arcache = 4'b0000;
    axi.arprot  = 3'b000;
    axi.arvalid = (state_q == S_AR);

    axi.rready  = (state_q == S_R) && rd_ready;
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: write/read bursts, error responses, length errors,
// mid-burst reset and the optional watchdog (AXI_MST_TIMEOUT_EN).
module tb_axi_burst_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [DW/8-1:0] wr_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done, done_lenerr;
  logic [1:0]    done_resp;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  axi_if_t #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) axi ();

  axi_burst_master #(
    .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW), .MST_ID(5), .TIMEOUT(16)
  ) dut (
    .clk(clk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_lenerr(done_lenerr),
    .dbg_state(dbg_state),
    .axi(axi)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    axi.awready = 0; axi.wready = 0;
    axi.bid = '0; axi.bresp = 2'b00; axi.bvalid = 0;
    axi.arready = 0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 0; axi.rvalid = 0;
  endtask

  // driver: one write burst with optional AW delay and toggling wready
  task automatic do_write(input logic [3:0] len, input logic [31:0] addr, input int aw_delay,
                          input bit toggle_w, input logic [1:0] bresp, input logic [1:0] exp_resp);
    int beat;
    int cyc;
    cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
    #1;
    chk("wr_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    wr_valid = 1; wr_data = 32'hDEAD_0000; wr_strb = 4'hF;
    for (int k = 0; k <= aw_delay; k++) begin
      axi.awready = (k == aw_delay);
      #1;
      chk("awvalid", axi.awvalid, 1);
      chk("awaddr", axi.awaddr, addr);
      chk("awlen", axi.awlen, len);
      chk("wvalid_before_aw", axi.wvalid, 0);
      chk("wr_ready_before_aw", wr_ready, 0);
      if (k == 0) begin
        chk("awsize", axi.awsize, 3'd2);
        chk("awburst", axi.awburst, 2'b01);
        chk("awid", axi.awid, 4'd5);
      end
      tick;
    end
    axi.awready = 0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 64) begin
      wr_data = 32'hA000_0000 + beat;
      wr_strb = 4'(beat + 1);
      axi.wready = toggle_w ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("wvalid", axi.wvalid, 1);
      chk("wdata", axi.wdata, 32'hA000_0000 + beat);
      chk("wstrb", axi.wstrb, 4'(beat + 1));
      chk("wlast", axi.wlast, beat == int'(len));
      chk("wid", axi.wid, 4'd5);
      chk("wr_ready", wr_ready, axi.wready);
      if (axi.wready) beat++;
      tick;
      cyc++;
    end
    chk("w_beat_count", beat, int'(len) + 1);
    wr_valid = 0; axi.wready = 0;
    axi.bvalid = 1; axi.bresp = bresp;
    #1;
    chk("bready", axi.bready, 1);
    chk("done_before_b", done, 0);
    tick;
    axi.bvalid = 0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_done_resp", done_resp, exp_resp);
    chk("wr_done_cmd_ready", cmd_ready, 1);
    chk("wr_done_bready", axi.bready, 0);
    tick;
    chk("wr_done_pulse", done, 0);
  endtask

  // driver: one read burst; last_beat may differ from len, one rd_ready stall on beat 2
  task automatic do_read(input logic [3:0] len, input int last_beat, input int err_beat,
                         input logic [1:0] err_code, input logic [1:0] exp_resp, input bit exp_lenerr);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0000_2000 + len; cmd_len = len;
    rd_ready = 1;
    #1;
    chk("rd_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    axi.arready = 1;
    #1;
    chk("arvalid", axi.arvalid, 1);
    chk("araddr", axi.araddr, 32'h0000_2000 + len);
    chk("arlen", axi.arlen, len);
    chk("arsize", axi.arsize, 3'd2);
    chk("arid", axi.arid, 4'd5);
    chk("rready_before_r", axi.rready, 0);
    tick;
    axi.arready = 0;
    for (int b = 0; b <= last_beat; b++) begin
      axi.rvalid = 1;
      axi.rdata  = 32'hB000_0000 + b;
      axi.rresp  = (b == err_beat) ? err_code : (b == err_beat + 1) ? 2'b11 : (b == 1) ? 2'b01 : 2'b00;
      axi.rlast  = (b == last_beat);
      if (b == 2) begin
        rd_ready = 0;
        #1;
        chk("rready_stall", axi.rready, 0);
        chk("rd_valid_stall", rd_valid, 1);
        tick;
        rd_ready = 1;
      end
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, 32'hB000_0000 + b);
      chk("rd_last", rd_last, b == last_beat);
      chk("rready", axi.rready, 1);
      chk("rd_no_early_done", done, 0);
      tick;
    end
    axi.rvalid = 0; axi.rlast = 0; axi.rresp = 2'b00;
    #1;
    chk("rd_done", done, 1);
    chk("rd_done_resp", done_resp, exp_resp);
    chk("rd_done_lenerr", done_lenerr, exp_lenerr);
    chk("rd_done_state", dbg_state, 3'd0);
    tick;
    chk("rd_done_pulse", done, 0);
  endtask

  initial begin
    int nb;
    int nd;
    int cyc;
    idle_inputs();
    areset = 1;
    tick;
    tick;
    areset = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_done", done, 0);
    chk("rst_done_resp", done_resp, 2'b00);
    chk("rst_state", dbg_state, 3'd0);

    do_write(4'd3, 32'h0000_1000, 0, 1'b0, 2'b00, 2'b00);
    do_write(4'd3, 32'h0000_2040, 5, 1'b1, 2'b10, 2'b10);
    do_write(4'd0, 32'h0000_0030, 0, 1'b0, 2'b01, 2'b00);

    do_read(4'd7, 7, 3, 2'b10, 2'b10, 1'b0);
    do_read(4'd3, 1, 99, 2'b00, 2'b00, 1'b1);
    do_read(4'd1, 3, 2, 2'b11, 2'b11, 1'b1);

    // reset in the middle of a write burst
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_4000; cmd_len = 4'd3;
    tick;
    cmd_valid = 0;
    axi.awready = 1;
    tick;
    axi.awready = 0;
    wr_valid = 1; axi.wready = 1; wr_data = 32'h1;
    tick;
    areset = 1;
    #1;
    chk("rst_mid_wvalid_pre", axi.wvalid, 1);
    tick;
    areset = 0;
    #1;
    chk("rst_mid_awvalid", axi.awvalid, 0);
    chk("rst_mid_wvalid", axi.wvalid, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_state", dbg_state, 3'd0);
    wr_valid = 0; axi.wready = 0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (done) nd++;
    end
    chk("rst_mid_no_done", nd, 0);

    // write whose B response never arrives
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_5000; cmd_len = 4'd0;
    tick;
    cmd_valid = 0;
    axi.awready = 1;
    tick;
    axi.awready = 0;
    wr_valid = 1; axi.wready = 1; wr_data = 32'h55;
    #1;
    chk("stall_wlast", axi.wlast, 1);
    tick;
    wr_valid = 0; axi.wready = 0;
    nb = 0;
    cyc = 0;
`ifdef AXI_MST_TIMEOUT_EN
    while (done !== 1'b1 && cyc < 40) begin
      if (axi.bready) nb++;
      tick;
      cyc++;
    end
    chk("tmo_done", done, 1);
    chk("tmo_wait_cycles", nb, 16);
    chk("tmo_resp", done_resp, 2'b11);
    chk("tmo_bready", axi.bready, 0);
    chk("tmo_cmd_ready", cmd_ready, 1);
    tick;
    chk("tmo_done_pulse", done, 0);
`else
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (axi.bready) nb++;
      if (done) nd++;
      tick;
    end
    chk("no_tmo_done", nd, 0);
    chk("no_tmo_bready", nb, 40);
    areset = 1;
    tick;
    areset = 0;
    #1;
    chk("no_tmo_rst_state", dbg_state, 3'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
